// File: rtl/des_sbox_rom_sequencer.sv
// des_sbox_rom_sequencer
//
// Purpose: time-shares a single 512x4 S-box ROM (S1..S8 stored back to back)
// across the eight DES S-box lookups of one f-function round. A 48-bit
// post-key-XOR word is accepted, eight serial ROM reads are issued, and the
// returned nibbles are assembled into the 32-bit pre-P-permutation result.
// Only one operation is in flight at a time.
//
// Parameters:
//   ROM_LATENCY  cycles from rom_en/rom_addr to valid rom_data (1..4)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  input handshake; in_data[47-6k -: 6] is chunk k for S(k+1)
//   out_valid/ready output handshake; out_data[31-4k -: 4] = S(k+1)(chunk k)
//   rom_en          ROM read strobe
//   rom_addr        {k[2:0], chunk[5:0]} (tables stored in raw 6-bit index order)
//   rom_data        ROM read data, valid ROM_LATENCY cycles after rom_en
//   busy            high whenever the sequencer is not idle
//
// Optional build macro DES_SBOX_PERF_EN adds:
//   perf_ops        saturating count of completed output handshakes
//   perf_stall      saturating count of DONE cycles with out_ready low

module des_sbox_rom_sequencer #(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        rom_en,
  output logic [8:0]  rom_addr,
  input  logic [3:0]  rom_data,
  output logic        busy
`ifdef DES_SBOX_PERF_EN
  ,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [47:0] data_q;
  logic [2:0]  issue_k;
  logic [2:0]  ret_cnt;
  logic [5:0]  chunk;

  // Tag pipe mirrors the ROM read latency so each returning nibble knows
  // which S-box slot it belongs to.
  logic [ROM_LATENCY-1:0] tag_v;
  logic [2:0]             tag_k [ROM_LATENCY];

  logic accept;
  logic ret_fire;
  logic last_ret;

  // Built from state directly rather than in_ready to keep the handshake
  // free of a combinational loop through the FSM block.
  assign accept   = (state == IDLE) && in_valid && !rst;
  assign ret_fire = tag_v[ROM_LATENCY-1];
  assign last_ret = ret_fire && (ret_cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_en    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        // Held low while reset is asserted, high from the first cycle after.
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = ISSUE;
      end
      ISSUE: begin
        rom_en = 1'b1;
        if (issue_k == 3'd7) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    chunk = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (issue_k == 3'(j)) chunk = data_q[47-6*j -: 6];
    end
  end

  assign rom_addr = rom_en ? {issue_k, chunk} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      issue_k  <= '0;
      ret_cnt  <= '0;
      out_data <= '0;
      tag_v    <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) tag_k[i] <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        data_q   <= in_data;
        out_data <= '0;
        issue_k  <= '0;
        ret_cnt  <= '0;
      end else if (rom_en) begin
        issue_k <= issue_k + 3'd1;
      end

      tag_v[0] <= rom_en;
      tag_k[0] <= issue_k;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_k[i] <= tag_k[i-1];
      end

      // rom_data is only looked at on tag-valid cycles so undriven ROM
      // output never reaches out_data.
      if (ret_fire) begin
        ret_cnt <= ret_cnt + 3'd1;
        for (int unsigned j = 0; j < 8; j++) begin
          if (tag_k[ROM_LATENCY-1] == 3'(j)) out_data[31-4*j -: 4] <= rom_data;
        end
      end
    end
  end

`ifdef DES_SBOX_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready && (perf_ops != '1)) perf_ops <= perf_ops + 16'd1;
      if ((state == DONE) && !out_ready && (perf_stall != '1)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
